serial_send: RTL and testbench

- UART transmitter: accepts one byte on a single-cycle write strobe and shifts it out as one 8N1 asynchronous serial frame.
- Frame format: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Each bit lasts WAIT_DIV clock cycles.
- Sits between a byte-producing controller and the TX pin; BUSY provides flow control.

---
 rtl/serial_send.sv | 99 +++++++++
 tb/tb_serial_send.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serial_send.sv
// 8N1 UART transmitter: one byte per accepted write strobe, LSB first,
// each bit held WAIT_DIV clock cycles. All outputs are registered.
module serial_send #(
  parameter int unsigned WAIT_DIV = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       WE,
  output logic       DATA_OUT,
  output logic       BUSY
);

  localparam int unsigned CW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    next_idx;
  logic [7:0]    shift_reg;
  logic          bit_end;

  always_comb begin
    next_idx = bit_idx + 3'd1;
    bit_end  = (cnt == LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      DATA_OUT  <= 1'b1;
      BUSY      <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          DATA_OUT <= 1'b1;
          BUSY     <= 1'b0;
          if (WE) begin
            shift_reg <= DATA_IN;
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= START;
            DATA_OUT  <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt      <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            DATA_OUT <= shift_reg[0];
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              DATA_OUT <= 1'b1;
            end else begin
              // Output register is loaded with the bit for the upcoming slot.
              bit_idx  <= next_idx;
              DATA_OUT <= shift_reg[next_idx];
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt      <= '0;
            state    <= IDLE;
            BUSY     <= 1'b0;
            DATA_OUT <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state    <= IDLE;
          DATA_OUT <= 1'b1;
          BUSY     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_send.sv
// Directed bench for serial_send with WAIT_DIV=5: frame bits, timing, flow
// control, back-to-back frames and reset behaviour.
module tb_serial_send;

  localparam int WD = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DATA_IN = '0;
  logic       WE = 1'b0;
  logic       DATA_OUT;
  logic       BUSY;

  int unsigned tests = 0;
  int unsigned fails = 0;

  serial_send #(.WAIT_DIV(WD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA_IN  (DATA_IN),
    .WE       (WE),
    .DATA_OUT (DATA_OUT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check($sformatf("%s_busy%0d", tag, i), BUSY, 1'b0);
      check($sformatf("%s_line%0d", tag, i), DATA_OUT, 1'b1);
      @(negedge CLK);
    end
  endtask

  // Called at a negedge with the transmitter idle. Expected line level per
  // slot: start 0, data LSB first, stop 1.
  task automatic run_frame(input logic [7:0] b, input string tag,
                           input logic hold_we, input int poke_at,
                           input logic [7:0] poke_data, input logic poke_we);
    logic [9:0] ref_bits;
    ref_bits = {1'b1, b, 1'b0};
    DATA_IN  = b;
    WE       = 1'b1;
    @(negedge CLK);
    WE = hold_we;
    for (int n = 0; n < 10 * WD; n++) begin
      check($sformatf("%s_busy%0d", tag, n), BUSY, 1'b1);
      check($sformatf("%s_bit%0d", tag, n), DATA_OUT, ref_bits[n / WD]);
      if (n == poke_at) begin
        DATA_IN = poke_data;
        WE      = hold_we | poke_we;
      end else if (n == poke_at + 1) begin
        WE = hold_we;
      end
      @(negedge CLK);
    end
    check({tag, "_busy_end"}, BUSY, 1'b0);
    check({tag, "_line_end"}, DATA_OUT, 1'b1);
  endtask

  initial begin
    // Reset held two cycles, then idle with WE low
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_line", DATA_OUT, 1'b1);
    RST = 1'b0;
    check_idle("post_rst", 3);

    // Single frame 0x41: 0 | 1,0,0,0,0,0,1,0 | 1
    run_frame(8'h41, "f41", 1'b0, -1, 8'h00, 1'b0);
    check_idle("f41_after", 4);

    // WE pulse mid-frame with 0xFF must not disturb the 0x55 frame
    run_frame(8'h55, "f55", 1'b0, 12, 8'hFF, 1'b1);
    check_idle("f55_nosecond", 12);

    // WE held high: 0xA5 then 0x3C back-to-back, DATA_IN changed mid-frame
    run_frame(8'hA5, "fa5", 1'b1, 20, 8'h3C, 1'b1);
    run_frame(8'h3C, "f3c", 1'b0, -1, 8'h00, 1'b0);
    check_idle("f3c_after", 3);

    // Reset during data bit 3 of 0x96 (bit3 = 0)
    DATA_IN = 8'h96;
    WE      = 1'b1;
    @(negedge CLK);
    WE = 1'b0;
    for (int n = 0; n < 4 * WD + 2; n++) @(negedge CLK);
    check("mid_busy", BUSY, 1'b1);
    check("mid_bit3", DATA_OUT, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_line", DATA_OUT, 1'b1);
    RST = 1'b0;
    check_idle("mid_after", 3);
    run_frame(8'hC3, "fc3", 1'b0, -1, 8'h00, 1'b0);

    // WE and RST on the same edge: reset wins
    RST     = 1'b1;
    WE      = 1'b1;
    DATA_IN = 8'h00;
    @(negedge CLK);
    check("we_rst_busy", BUSY, 1'b0);
    check("we_rst_line", DATA_OUT, 1'b1);
    RST = 1'b0;
    WE  = 1'b0;
    check_idle("we_rst_after", 3);

    // Extremes
    run_frame(8'h00, "f00", 1'b0, -1, 8'h00, 1'b0);
    check_idle("f00_after", 2);
    run_frame(8'hFF, "fff", 1'b0, -1, 8'h00, 1'b0);
    check_idle("fff_after", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
